// File: rtl/ws2812b_rx.sv
// WS2812B single-wire NRZ receiver.
// Resynchronises the raw LED line, measures each high pulse, decodes it to a
// bit, assembles 24-bit GRB words (first bit in bit 23) and flags the latch
// low period that ends a frame. Runt pulses, stuck-high lines and words cut
// short by a latch are reported on err.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// WAIT_LOW | ignore the line until it is seen low (after reset / stuck high)
// LOW      | line low: inter-bit gap or latch period, low_cnt running
// HIGH     | line high: measuring the pulse width in high_cnt
module ws2812b_rx #(
  parameter int CLOCK_MHZ     = 64,
  parameter int BIT_THRESH_NS = 600,
  parameter int MIN_HIGH_NS   = 150,
  parameter int MAX_HIGH_NS   = 2000,
  parameter int RESET_US      = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] data_out,
  output logic        data_valid,
  output logic        latch,
  output logic [7:0]  pixel_count,
  output logic        err
);

  localparam int THRESH_CYC = CLOCK_MHZ * BIT_THRESH_NS / 1000;
  localparam int MIN_CYC    = CLOCK_MHZ * MIN_HIGH_NS / 1000;
  localparam int MAX_CYC    = CLOCK_MHZ * MAX_HIGH_NS / 1000;
  localparam int RESET_CYC  = CLOCK_MHZ * RESET_US;
  localparam int BIG_CYC    = (RESET_CYC > MAX_CYC) ? RESET_CYC : MAX_CYC;
  localparam int CNT_W      = $clog2(BIG_CYC) + 1;

  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH_C    = CNT_W'(THRESH_CYC);
  localparam logic [CNT_W-1:0] MIN_C       = CNT_W'(MIN_CYC);
  localparam logic [CNT_W-1:0] MAX_LAST_C  = CNT_W'(MAX_CYC - 1);
  localparam logic [CNT_W-1:0] RESET_C     = CNT_W'(RESET_CYC);
  localparam logic [CNT_W-1:0] RESET_LAST_C = CNT_W'(RESET_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    LOW      = 2'd1,
    HIGH     = 2'd2
  } state_t;

  state_t           state;
  logic             din_meta;
  logic             din_s;
  logic             din_prev;
  logic             rise;
  logic             fall;
  logic             bit_val;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [4:0]       bit_cnt;
  logic [23:0]      shift_reg;
  logic             frame_active;

  // Two-flop synchroniser for the asynchronous line, plus a history flop for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_meta <= 1'b0;
      din_s    <= 1'b0;
      din_prev <= 1'b0;
    end else begin
      din_meta <= din;
      din_s    <= din_meta;
      din_prev <= din_s;
    end
  end

  assign rise    = din_s & ~din_prev;
  assign fall    = ~din_s & din_prev;
  // At the falling edge high_cnt equals the number of high cycles seen.
  assign bit_val = (high_cnt >= THRESH_C);

  // Pulse measurement, bit/word assembly, latch detection and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_LOW;
      high_cnt     <= '0;
      low_cnt      <= '0;
      bit_cnt      <= 5'd0;
      shift_reg    <= 24'd0;
      frame_active <= 1'b0;
      data_out     <= 24'd0;
      data_valid   <= 1'b0;
      latch        <= 1'b0;
      pixel_count  <= 8'd0;
      err          <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      latch      <= 1'b0;
      err        <= 1'b0;
      // pixel_count stays readable during the latch pulse, then clears.
      if (latch) pixel_count <= 8'd0;

      case (state)
        WAIT_LOW: begin
          if (!din_s) begin
            // This cycle is already the first low cycle.
            low_cnt <= ONE_C;
            state   <= LOW;
          end
        end

        LOW: begin
          if (rise) begin
            // The rising-edge cycle counts as the first high cycle.
            high_cnt <= ONE_C;
            low_cnt  <= '0;
            state    <= HIGH;
          end else if (low_cnt < RESET_C) begin
            low_cnt <= low_cnt + ONE_C;
            if ((low_cnt == RESET_LAST_C) && frame_active) begin
              latch        <= 1'b1;
              err          <= (bit_cnt != 5'd0);
              bit_cnt      <= 5'd0;
              frame_active <= 1'b0;
            end
          end
        end

        HIGH: begin
          if (fall) begin
            if (high_cnt < MIN_C) begin
              err     <= 1'b1;
              bit_cnt <= 5'd0;
            end else begin
              frame_active <= 1'b1;
              shift_reg    <= {shift_reg[22:0], bit_val};
              if (bit_cnt == 5'd23) begin
                data_out   <= {shift_reg[22:0], bit_val};
                data_valid <= 1'b1;
                bit_cnt    <= 5'd0;
                if (pixel_count != 8'hFF) pixel_count <= pixel_count + 8'd1;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
            low_cnt <= ONE_C;
            state   <= LOW;
          end else if (high_cnt == MAX_LAST_C) begin
            // Line has been high for the full limit: treat as stuck.
            err     <= 1'b1;
            bit_cnt <= 5'd0;
            state   <= WAIT_LOW;
          end else begin
            high_cnt <= high_cnt + ONE_C;
          end
        end

        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule
